// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Sits in EX beside the ALU; its result replaces alu_out in EX/MEM. Normal
// operations take one acceptance edge, XLEN restoring steps and one sign-fix
// edge. Divide-by-zero and signed overflow can optionally complete at the
// acceptance edge.
//
// Ports:
//   clk      pipeline clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request a divide; accepted only while idle and not flushed
//   op       00 DIV, 01 DIVU, 10 REM, 11 REMU (bit0 unsigned, bit1 remainder)
//   div_in1  dividend (rs1)
//   div_in2  divisor (rs2)
//   flush    kill any operation in flight
//   busy     high from the edge after acceptance until the result is loaded
//   done     one-cycle pulse when result becomes valid
//   result   quotient or remainder, held until the next completion
// ----------------------------------------------------------------------------
module div_unit #(
  parameter int unsigned XLEN         = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] div_in1,
  input  logic [XLEN-1:0] div_in2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CW       = $clog2(XLEN);
  localparam int unsigned     RW       = XLEN + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Datapath registers and their next values
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;           // partial remainder
  logic [XLEN-1:0] quo_q, quo_d;           // dividend bits out, quotient bits in
  logic [XLEN-1:0] dvs_q, dvs_d;           // divisor magnitude
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            sel_rem_q, sel_rem_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] special_val_q, special_val_d;
  logic            busy_d, done_d;
  logic [XLEN-1:0] result_d;

  // Operand decode at acceptance
  logic            signed_op_c;
  logic            in1_neg_c, in2_neg_c;
  logic [XLEN-1:0] mag1_c, mag2_c;
  logic            div_zero_c, overflow_c, special_c;
  logic [XLEN-1:0] special_val_c;
  logic            accept_c, fast_c;

  assign signed_op_c = ~op[0];
  assign in1_neg_c   = signed_op_c & div_in1[XLEN-1];
  assign in2_neg_c   = signed_op_c & div_in2[XLEN-1];
  // INT_MIN negates to itself, which reads correctly as unsigned 2^(XLEN-1)
  assign mag1_c      = in1_neg_c ? -div_in1 : div_in1;
  assign mag2_c      = in2_neg_c ? -div_in2 : div_in2;

  assign div_zero_c  = (div_in2 == '0);
  assign overflow_c  = signed_op_c && (div_in1 == INT_MIN) && (div_in2 == '1);
  assign special_c   = div_zero_c | overflow_c;

  // Architected results for the two special cases
  always_comb begin
    special_val_c = '0;
    if (div_zero_c) begin
      special_val_c = op[1] ? div_in1 : '1;
    end else begin
      special_val_c = op[1] ? '0 : INT_MIN;
    end
  end

  assign accept_c = (state_q == S_IDLE) && start && !flush;
  assign fast_c   = FAST_SPECIAL && special_c;

  // One restoring step on a one-bit-wider partial remainder
  logic [RW-1:0]   shift_c, diff_c;
  logic            qbit_c;

  assign shift_c = {rem_q, quo_q[XLEN-1]};
  assign diff_c  = shift_c - {1'b0, dvs_q};
  assign qbit_c  = ~diff_c[XLEN];

  // Sign correction and result selection for the FIX edge
  logic [XLEN-1:0] quo_fix_c, rem_fix_c, fix_val_c;

  assign quo_fix_c = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix_c = neg_rem_q ? -rem_q : rem_q;
  assign fix_val_c = special_q ? special_val_q : (sel_rem_q ? rem_fix_c : quo_fix_c);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (accept_c && !fast_c) state_d = S_CALC;
        S_CALC:  if (cnt_q == '0) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    sel_rem_d     = sel_rem_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    busy_d        = busy;
    done_d        = 1'b0;
    result_d      = result;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sel_rem_d     = op[1];
          neg_quo_d     = in1_neg_c ^ in2_neg_c;
          neg_rem_d     = in1_neg_c;
          special_d     = special_c;
          special_val_d = special_val_c;
          if (fast_c) begin
            result_d = special_val_c;
            done_d   = 1'b1;
          end else begin
            busy_d = 1'b1;
            cnt_d  = CNT_LAST;
            rem_d  = '0;
            quo_d  = mag1_c;
            dvs_d  = mag2_c;
          end
        end
      end
      S_CALC: begin
        rem_d = qbit_c ? diff_c[XLEN-1:0] : shift_c[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], qbit_c};
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        result_d = fix_val_c;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end
      default: ;
    endcase

    // A killed operation never completes and never touches result
    if (flush) begin
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      sel_rem_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
    end else begin
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      sel_rem_q     <= sel_rem_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      busy          <= busy_d;
      done          <= done_d;
      result        <= result_d;
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the combinational ALU and takes the same two operands from the ID/EX register.
- Its result is muxed into EX/MEM in place of alu_out.
- Replaces the single-cycle divide path so that the critical path stays in the adder/shifter. The hazard unit stalls the pipeline while busy is high.

Parameters:
XLEN, 32, operand and result width
FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle; when 0, they take the full iterative latency with the same results

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a divide; accepted only when busy is 0
op  input  2  00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU; bit0 selects unsigned, bit1 selects remainder
div_in1  input  XLEN  dividend (rs1)
div_in2  input  XLEN  divisor (rs2)
flush  input  1  kill any operation in flight (branch mispredict or trap)
busy  output  1  high from the edge after acceptance until the result is loaded
done  output  1  one-cycle pulse when result becomes valid
result  output  XLEN  quotient or remainder; holds its value until the next accepted start

Behaviour:
- Reset (async, rst_n = 0): state = IDLE; busy = 0; done = 0; result = 0; internal registers = 0.
- States:
  - IDLE: accepts start.
  - CALC: 32 iterations.
  - FIX: sign correction and result load.
- Acceptance: at a rising edge where state = IDLE, start = 1 and flush = 0, the block latches op, the operands, neg_q and neg_r.
  - Signed ops: neg_q = sign(in1) XOR sign(in2); neg_r = sign(in1).
  - Unsigned ops: both are 0.
  - Magnitudes |in1| and |in2| are loaded, with 0x80000000 treated as unsigned 2^31.
- Special cases, checked at acceptance:
  - div_in2 = 0: quotient = 0xFFFFFFFF; remainder = div_in1 (all ops).
  - Signed op with div_in1 = 0x80000000 and div_in2 = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - With FAST_SPECIAL = 1, result is loaded at the acceptance edge, done = 1 in the next cycle, busy is never raised, and state stays IDLE.
- Normal path:
  - Acceptance edge moves the block to CALC with counter = 31; busy = 1.
  - Each CALC edge is one restoring step on a 33-bit partial remainder: shift left, bring in the next dividend bit, subtract the divisor when non-negative, shift a quotient bit in.
  - At counter = 0 the block moves to FIX.
  - The FIX edge applies the sign (negate the quotient if neg_q; negate the remainder if neg_r), loads result, pulses done, clears busy and returns to IDLE.
- Latency: done is high in the cycle following edge 33 after acceptance, i.e. 34 cycles from the start cycle to the done cycle. Fast special cases take 1 cycle.
- done is a single-cycle pulse. start is accepted in the same cycle that done is high, giving back-to-back operation.
- start while busy: ignored, with no effect on the operation in flight. The operands need not be held after acceptance.
- flush:
  - At any edge, flush = 1 forces state = IDLE and busy = 0. done is not asserted for the killed operation and result keeps its previous value.
  - flush and start in the same IDLE cycle: flush wins and nothing is accepted.
  - flush in the FIX cycle: the result is not loaded and done stays 0.
- Reset mid-operation: immediate return to reset values; no done.
- Result widths: all arithmetic is in XLEN bits, with the 33-bit internal remainder for the subtract step. Negation is two's complement modulo 2^XLEN.

Test Plan:
- DIV -7 (0xFFFFFFF9) / 2 -> result 0xFFFFFFFD (-3), done 34 cycles after start; REM with the same operands -> 0xFFFFFFFF (-1); busy high for cycles 1..33.
- DIVU 0xFFFFFFFF / 3 -> 0x55555555; REMU 100 / 7 -> 2; issue the second start in the done cycle -> accepted, second done 34 cycles later.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, done 1 cycle after start (FAST_SPECIAL = 1), busy never high.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5; DIV -5 / 0 -> 0xFFFFFFFF and REM -> 0xFFFFFFFB, each done after 1 cycle.
- Start DIV 1000 / 10, assert flush at cycle 12 -> busy drops next edge, no done pulse, result unchanged; a new DIV 9 / 3 started afterwards -> 3.
- Deassert rst_n asynchronously mid-CALC -> busy, done and result are 0 immediately; a start pulsed while busy (operands 8 / 2) is ignored and the original operation's result appears.
